craps_game_ctrl: RTL and testbench

Parametrised craps game controller that replaces the single-shot game FSM on the board. It plays repeated games, detects roll edges so a held DiceRolled button counts as one roll, and rejects out-of-range sums. It adds a point-phase roll limit and saturating win/loss score counters. It sits between the dice roller (DiceRolled, DiceSum) and the LED/seven-segment display logic.

---
 rtl/craps_game_ctrl.sv | 177 +++++++++++++++++
 tb/tb_craps_game_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/craps_game_ctrl.sv
// Craps game controller: plays repeated games from edge-detected dice rolls,
// enforces an optional point-phase roll limit and keeps saturating win/loss scores.
module craps_game_ctrl #(
    parameter int SUM_W     = 4,
    parameter int MAX_ROLLS = 15,
    parameter int CNT_W     = 8
) (
    input  logic             Clk100MHz,
    input  logic             reset,
    input  logic             DiceRolled,
    input  logic [SUM_W-1:0] DiceSum,
    input  logic             NewGame,
    output logic [2:0]       present_state,
    output logic [SUM_W-1:0] MyPoint,
    output logic             PointValid,
    output logic             RollDiceLed,
    output logic             PlayerWinsLed,
    output logic             PlayerLosesLed,
    output logic             BadRoll,
    output logic [CNT_W-1:0] RollCount,
    output logic [CNT_W-1:0] WinCount,
    output logic [CNT_W-1:0] LossCount
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EVAL1 = 3'd1,
        S_WON   = 3'd2,
        S_LOSE  = 3'd3,
        S_POINT = 3'd4,
        S_EVAL2 = 3'd5,
        S_END   = 3'd6
    } state_t;

    state_t           state_q;
    logic             dice_rolled_q;
    logic [SUM_W-1:0] roll_sum_q;
    logic [SUM_W-1:0] my_point_q;
    logic             point_valid_q;
    logic             roll_led_q;
    logic             win_led_q;
    logic             lose_led_q;
    logic             bad_roll_q;
    logic [CNT_W-1:0] roll_cnt_q;
    logic [CNT_W-1:0] win_cnt_q;
    logic [CNT_W-1:0] loss_cnt_q;

    logic             roll_evt_s;
    logic             sum_ok_s;
    logic             limit_hit_s;
    logic [CNT_W-1:0] roll_cnt_d;
    logic [CNT_W:0]   roll_cnt_ext_s;

    assign roll_evt_s     = DiceRolled & ~dice_rolled_q;
    assign sum_ok_s       = (DiceSum >= SUM_W'(2)) && (DiceSum <= SUM_W'(12));
    assign roll_cnt_d     = roll_cnt_q + CNT_W'(1);
    // Extra bit so a limit equal to 2^CNT_W is compared without wrapping.
    assign roll_cnt_ext_s = {1'b0, roll_cnt_q} + (CNT_W+1)'(1);
    assign limit_hit_s    = (MAX_ROLLS != 0) && (roll_cnt_ext_s == (CNT_W+1)'(MAX_ROLLS));

    // Game state machine with all outputs registered alongside the state.
    always_ff @(posedge Clk100MHz) begin
        if (reset) begin
            state_q       <= S_IDLE;
            dice_rolled_q <= 1'b0;
            roll_sum_q    <= '0;
            my_point_q    <= '0;
            point_valid_q <= 1'b0;
            roll_led_q    <= 1'b1;
            win_led_q     <= 1'b0;
            lose_led_q    <= 1'b0;
            bad_roll_q    <= 1'b0;
            roll_cnt_q    <= '0;
            win_cnt_q     <= '0;
            loss_cnt_q    <= '0;
        end else begin
            dice_rolled_q <= DiceRolled;
            bad_roll_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (roll_evt_s && sum_ok_s) begin
                        state_q    <= S_EVAL1;
                        roll_sum_q <= DiceSum;
                        roll_led_q <= 1'b0;
                    end else if (roll_evt_s) begin
                        bad_roll_q <= 1'b1;
                    end
                end
                S_EVAL1: begin
                    case (roll_sum_q)
                        SUM_W'(7), SUM_W'(11): begin
                            state_q   <= S_WON;
                            win_led_q <= 1'b1;
                        end
                        SUM_W'(2), SUM_W'(3), SUM_W'(12): begin
                            state_q    <= S_LOSE;
                            lose_led_q <= 1'b1;
                        end
                        default: begin
                            state_q       <= S_POINT;
                            my_point_q    <= roll_sum_q;
                            point_valid_q <= 1'b1;
                            roll_led_q    <= 1'b1;
                        end
                    endcase
                end
                S_POINT: begin
                    if (roll_evt_s && sum_ok_s) begin
                        state_q    <= S_EVAL2;
                        roll_sum_q <= DiceSum;
                        roll_led_q <= 1'b0;
                    end else if (roll_evt_s) begin
                        bad_roll_q <= 1'b1;
                    end
                end
                S_EVAL2: begin
                    // A seven loses even if it happens to match the point.
                    if (roll_sum_q == SUM_W'(7)) begin
                        state_q    <= S_LOSE;
                        lose_led_q <= 1'b1;
                    end else if (roll_sum_q == my_point_q) begin
                        state_q   <= S_WON;
                        win_led_q <= 1'b1;
                    end else begin
                        roll_cnt_q <= roll_cnt_d;
                        if (limit_hit_s) begin
                            state_q    <= S_LOSE;
                            lose_led_q <= 1'b1;
                        end else begin
                            state_q    <= S_POINT;
                            roll_led_q <= 1'b1;
                        end
                    end
                end
                S_WON: begin
                    state_q <= S_END;
                    if (win_cnt_q != {CNT_W{1'b1}}) begin
                        win_cnt_q <= win_cnt_q + CNT_W'(1);
                    end
                end
                S_LOSE: begin
                    state_q <= S_END;
                    if (loss_cnt_q != {CNT_W{1'b1}}) begin
                        loss_cnt_q <= loss_cnt_q + CNT_W'(1);
                    end
                end
                S_END: begin
                    if (NewGame) begin
                        state_q       <= S_IDLE;
                        win_led_q     <= 1'b0;
                        lose_led_q    <= 1'b0;
                        my_point_q    <= '0;
                        point_valid_q <= 1'b0;
                        roll_cnt_q    <= '0;
                        roll_led_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    roll_led_q <= 1'b1;
                end
            endcase
        end
    end

    assign present_state  = state_q;
    assign MyPoint        = my_point_q;
    assign PointValid     = point_valid_q;
    assign RollDiceLed    = roll_led_q;
    assign PlayerWinsLed  = win_led_q;
    assign PlayerLosesLed = lose_led_q;
    assign BadRoll        = bad_roll_q;
    assign RollCount      = roll_cnt_q;
    assign WinCount       = win_cnt_q;
    assign LossCount      = loss_cnt_q;

endmodule

// File: tb/tb_craps_game_ctrl.sv
// Scoreboard bench for craps_game_ctrl: two instances (roll limit 3 / 2-bit scores,
// and no roll limit / 8-bit scores) against a game-level reference model.
module tb_craps_game_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [2];
    logic       dr  [2];
    logic [3:0] ds  [2];
    logic       ng  [2];
    logic [2:0] st  [2];
    logic [3:0] mp  [2];
    logic       pv  [2];
    logic       rdl [2];
    logic       wl  [2];
    logic       ll  [2];
    logic       br  [2];
    logic [7:0] rc  [2];
    logic [7:0] wc  [2];
    logic [7:0] lc  [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int CW = (g == 0) ? 2 : 8;
        logic [2:0]    st_w;
        logic [3:0]    mp_w;
        logic          pv_w, rdl_w, wl_w, ll_w, br_w;
        logic [CW-1:0] rc_w, wc_w, lc_w;

        craps_game_ctrl #(
            .SUM_W    (4),
            .MAX_ROLLS((g == 0) ? 3 : 0),
            .CNT_W    (CW)
        ) u_dut (
            .Clk100MHz     (clk),
            .reset         (rst[g]),
            .DiceRolled    (dr[g]),
            .DiceSum       (ds[g]),
            .NewGame       (ng[g]),
            .present_state (st_w),
            .MyPoint       (mp_w),
            .PointValid    (pv_w),
            .RollDiceLed   (rdl_w),
            .PlayerWinsLed (wl_w),
            .PlayerLosesLed(ll_w),
            .BadRoll       (br_w),
            .RollCount     (rc_w),
            .WinCount      (wc_w),
            .LossCount     (lc_w)
        );

        assign st[g]  = st_w;
        assign mp[g]  = mp_w;
        assign pv[g]  = pv_w;
        assign rdl[g] = rdl_w;
        assign wl[g]  = wl_w;
        assign ll[g]  = ll_w;
        assign br[g]  = br_w;
        assign rc[g]  = 8'(rc_w);
        assign wc[g]  = 8'(wc_w);
        assign lc[g]  = 8'(lc_w);
    end

    // kind: 0 = rejected roll, 1 = game finished, 2 = new game started
    typedef struct {
        int kind;
        int st;
        int win;
        int wins;
        int losses;
        int point;
        int rolls;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;
    int   prev_st [2] = '{0, 0};

    // Reference model, one game per instance; phase 0 = come-out, 1 = point, 2 = over.
    int m_phase  [2];
    int m_point  [2];
    int m_rolls  [2];
    int m_wins   [2];
    int m_losses [2];
    int maxr [2] = '{3, 0};
    int cmax [2] = '{3, 255};

    task automatic chk(string name, int idx, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s dut%0d: got %0d expected %0d at %0t", name, idx, act, exp, $time);
        end
    endtask

    function automatic void push(int idx, exp_t e);
        if (idx == 0) q0.push_back(e);
        else q1.push_back(e);
    endfunction

    task automatic pop(int idx, output exp_t e, output bit ok);
        e  = '{default: 0};
        ok = 1'b0;
        if (idx == 0 && q0.size() > 0) begin
            e = q0.pop_front(); ok = 1'b1;
        end else if (idx == 1 && q1.size() > 0) begin
            e = q1.pop_front(); ok = 1'b1;
        end
    endtask

    function automatic void model_reset(int idx, bit scores);
        m_phase[idx] = 0;
        m_point[idx] = 0;
        m_rolls[idx] = 0;
        if (scores) begin
            m_wins[idx]   = 0;
            m_losses[idx] = 0;
        end
    endfunction

    function automatic void finish_game(int idx, bit w);
        exp_t e = '{default: 0};
        if (w) m_wins[idx]   = (m_wins[idx] < cmax[idx]) ? m_wins[idx] + 1 : cmax[idx];
        else   m_losses[idx] = (m_losses[idx] < cmax[idx]) ? m_losses[idx] + 1 : cmax[idx];
        m_phase[idx] = 2;
        e.kind   = 1;
        e.win    = w;
        e.wins   = m_wins[idx];
        e.losses = m_losses[idx];
        e.point  = m_point[idx];
        e.rolls  = m_rolls[idx];
        push(idx, e);
    endfunction

    function automatic void model_roll(int idx, int s);
        exp_t e = '{default: 0};
        if (m_phase[idx] == 2) return;
        if (s < 2 || s > 12) begin
            e.kind = 0;
            e.st   = (m_phase[idx] == 0) ? 0 : 4;
            push(idx, e);
        end else if (m_phase[idx] == 0) begin
            if (s == 7 || s == 11) finish_game(idx, 1'b1);
            else if (s == 2 || s == 3 || s == 12) finish_game(idx, 1'b0);
            else begin
                m_phase[idx] = 1;
                m_point[idx] = s;
            end
        end else begin
            if (s == 7) finish_game(idx, 1'b0);
            else if (s == m_point[idx]) finish_game(idx, 1'b1);
            else begin
                m_rolls[idx]++;
                if (maxr[idx] != 0 && m_rolls[idx] == maxr[idx]) finish_game(idx, 1'b0);
            end
        end
    endfunction

    function automatic int rand_sum();
        int iv;
        if ($urandom_range(0, 9) == 0) begin
            iv = $urandom_range(0, 4);
            return (iv < 2) ? iv : iv + 11;
        end
        return $urandom_range(1, 6) + $urandom_range(1, 6);
    endfunction

    task automatic mon(int i);
        int   s;
        exp_t e;
        bit   ok;
        s = int'(st[i]);
        chk("roll_led", i, int'(rdl[i]), (s == 0 || s == 4) ? 1 : 0);
        if (s == 2) chk("win_led_in_won", i, int'(wl[i]), 1);
        if (s == 3) chk("lose_led_in_lose", i, int'(ll[i]), 1);
        if (br[i]) begin
            pop(i, e, ok);
            chk("bad_roll_expected", i, int'(ok && e.kind == 0), 1);
            if (ok && e.kind == 0) chk("bad_roll_state", i, s, e.st);
        end
        if (s == 6 && prev_st[i] != 6) begin
            pop(i, e, ok);
            chk("game_end_expected", i, int'(ok && e.kind == 1), 1);
            if (ok && e.kind == 1) begin
                chk("end_win_led", i, int'(wl[i]), e.win);
                chk("end_lose_led", i, int'(ll[i]), 1 - e.win);
                chk("end_win_count", i, int'(wc[i]), e.wins);
                chk("end_loss_count", i, int'(lc[i]), e.losses);
                chk("end_my_point", i, int'(mp[i]), e.point);
                chk("end_point_valid", i, int'(pv[i]), (e.point != 0) ? 1 : 0);
                chk("end_roll_count", i, int'(rc[i]), e.rolls);
            end
        end
        if (s == 0 && prev_st[i] == 6) begin
            pop(i, e, ok);
            chk("new_game_expected", i, int'(ok && e.kind == 2), 1);
            if (ok && e.kind == 2) begin
                chk("ng_leds", i, int'({wl[i], ll[i]}), 0);
                chk("ng_point", i, int'({pv[i], mp[i]}), 0);
                chk("ng_roll_count", i, int'(rc[i]), 0);
                chk("ng_win_count", i, int'(wc[i]), e.wins);
                chk("ng_loss_count", i, int'(lc[i]), e.losses);
            end
        end
        prev_st[i] = s;
    endtask

    // Monitor: compares DUT outputs against queued expectations away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 2; i++) mon(i);
        end
    end

    task automatic do_roll(int idx, int s, int hold, bit ng_too);
        bit ng_ok;
        ng_ok = ng_too && (m_phase[idx] != 2);
        model_roll(idx, s);
        @(negedge clk);
        dr[idx] = 1'b1;
        ds[idx] = 4'(s);
        ng[idx] = ng_ok;
        @(negedge clk);
        ng[idx] = 1'b0;
        repeat (hold - 1) @(negedge clk);
        dr[idx] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic new_game(int idx, bit with_roll);
        exp_t e = '{default: 0};
        e.kind   = 2;
        e.wins   = m_wins[idx];
        e.losses = m_losses[idx];
        push(idx, e);
        model_reset(idx, 1'b0);
        @(negedge clk);
        ng[idx] = 1'b1;
        if (with_roll) begin
            dr[idx] = 1'b1;
            ds[idx] = 4'(rand_sum());
        end
        @(negedge clk);
        ng[idx] = 1'b0;
        dr[idx] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic play_random(int idx, int games);
        for (int g = 0; g < games; g++) begin
            int n = 0;
            while (m_phase[idx] != 2 && n < 80) begin
                do_roll(idx, rand_sum(), $urandom_range(1, 3), $urandom_range(0, 3) == 0);
                n++;
            end
            if (m_phase[idx] == 2) begin
                if ($urandom_range(0, 2) == 0) do_roll(idx, rand_sum(), 1, 1'b0);
                new_game(idx, $urandom_range(0, 1) == 1);
            end
        end
    endtask

    initial begin
        int nd [5] = '{4, 6, 8, 9, 10};
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1;
            dr[i]  = 1'b0;
            ds[i]  = 4'd0;
            ng[i]  = 1'b0;
            model_reset(i, 1'b1);
        end
        repeat (2) @(negedge clk);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_state", i, int'(st[i]), 0);
            chk("rst_roll_led", i, int'(rdl[i]), 1);
            chk("rst_outputs", i, int'({mp[i], pv[i], wl[i], ll[i], br[i]}), 0);
            chk("rst_counts", i, int'({rc[i], wc[i], lc[i]}), 0);
        end
        mon_en = 1'b1;

        // Instance 1: no roll limit, 8-bit scores.
        do_roll(1, 7, 1, 1'b0);
        chk("come_out_7_point", 1, int'(mp[1]), 0);
        new_game(1, 1'b0);
        do_roll(1, 4, 2, 1'b0);
        chk("point_4_state", 1, int'(st[1]), 4);
        chk("point_4_value", 1, int'(mp[1]), 4);
        do_roll(1, 9, 1, 1'b0);
        chk("nondeciding_count", 1, int'(rc[1]), 1);
        do_roll(1, 7, 1, 1'b0);
        new_game(1, 1'b1);
        do_roll(1, 13, 1, 1'b0);
        do_roll(1, 0, 1, 1'b0);
        chk("bad_rolls_idle", 1, int'(st[1]), 0);
        do_roll(1, 5, 50, 1'b0);
        for (int k = 0; k < 20; k++) do_roll(1, nd[k % 5], 1, k[0]);
        chk("no_limit_state", 1, int'(st[1]), 4);
        chk("no_limit_count", 1, int'(rc[1]), 20);
        do_roll(1, 5, 1, 1'b0);
        new_game(1, 1'b0);
        play_random(1, 40);

        // Instance 0: limit of three point-phase rolls, 2-bit scores.
        do_roll(0, 6, 1, 1'b0);
        do_roll(0, 5, 1, 1'b0);
        do_roll(0, 8, 1, 1'b0);
        do_roll(0, 9, 1, 1'b0);
        chk("limit_loss_count", 0, int'(rc[0]), 3);
        new_game(0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            do_roll(0, 11, 1, 1'b0);
            new_game(0, 1'b0);
        end
        chk("win_count_saturated", 0, int'(wc[0]), 3);
        do_roll(0, 8, 1, 1'b0);
        @(negedge clk);
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        model_reset(0, 1'b1);
        chk("mid_rst_state", 0, int'(st[0]), 0);
        chk("mid_rst_roll_led", 0, int'(rdl[0]), 1);
        chk("mid_rst_outputs", 0, int'({mp[0], pv[0], wl[0], ll[0], br[0]}), 0);
        chk("mid_rst_counts", 0, int'({rc[0], wc[0], lc[0]}), 0);
        play_random(0, 40);

        repeat (5) @(negedge clk);
        chk("queue0_drained", 0, q0.size(), 0);
        chk("queue1_drained", 1, q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
